// File: rtl/fir_tap_sequencer.sv
// ---------------------------------------------------------------------------
// fir_tap_sequencer
//
// Time-multiplexed FIR control stage for a single macc_core DSP slice.
// Each accepted input sample is written into a circular delay line. The FSM
// then streams NTAPS (sample, coefficient) operand pairs into macc_core,
// pulses sload so the accumulator restarts on tap 0, and registers the
// full-precision accumulator result onto the output stream.
//
// Ports
//   clk, rst          : clock (rising edge), synchronous active-high reset
//   s_axis_*          : input sample stream (SDW-bit signed samples)
//   m_axis_*          : output stream, y[n] as ODW-bit signed value
//   coef_wr/addr/data : coefficient write port, accepted when coef_ready=1
//   coef_ready        : high only while idle between samples
//   macc_ce           : clock enable to macc_core, low only during rst
//   macc_sload        : accumulator reload, one cycle after tap 0 operands
//   macc_a, macc_b    : sample / coefficient operands, zero outside RUN
//   macc_accum        : accumulator result from macc_core
// ---------------------------------------------------------------------------
module fir_tap_sequencer #(
    parameter int SDW   = 24,
    parameter int CDW   = 18,
    parameter int ODW   = 48,
    parameter int NTAPS = 16,
    localparam int AW   = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
    input  logic           clk,
    input  logic           rst,

    input  logic [SDW-1:0] s_axis_tdata,
    input  logic           s_axis_tvalid,
    output logic           s_axis_tready,

    output logic [ODW-1:0] m_axis_tdata,
    output logic           m_axis_tvalid,
    input  logic           m_axis_tready,

    input  logic           coef_wr,
    input  logic [AW-1:0]  coef_addr,
    input  logic [CDW-1:0] coef_data,
    output logic           coef_ready,

    output logic           macc_ce,
    output logic           macc_sload,
    output logic [SDW-1:0] macc_a,
    output logic [CDW-1:0] macc_b,
    input  logic [ODW-1:0] macc_accum
);

    // -----------------------------------------------------------------------
    // State encoding
    // -----------------------------------------------------------------------
    localparam logic [2:0] ST_CLEAR = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_OUT   = 3'd4;

    // Address mask keeps every pointer inside the NTAPS-entry arrays; with a
    // power-of-two NTAPS this is the natural modulo wrap (and forces 0 when
    // NTAPS=1, where AW is padded to one bit).
    localparam logic [AW-1:0] ADDR_MASK = AW'(NTAPS - 1);
    localparam logic [AW-1:0] LAST_TAP  = AW'(NTAPS - 1);

    // macc_core result for the last tap is valid on the third DRAIN cycle:
    // one cycle of operand registering, one of multiply, one of accumulate.
    localparam logic [1:0]    DRAIN_LAST = 2'd2;

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    logic [SDW-1:0] r_dline [NTAPS];
    logic [CDW-1:0] r_coef  [NTAPS];

    // -----------------------------------------------------------------------
    // Control registers
    // -----------------------------------------------------------------------
    logic [2:0]     r_state;
    logic [AW-1:0]  r_clr_cnt;
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_base;
    logic [AW-1:0]  r_tap;
    logic [1:0]     r_drain;
    logic           r_sload;
    logic [ODW-1:0] r_tdata;

    // -----------------------------------------------------------------------
    // Decodes
    // -----------------------------------------------------------------------
    logic           w_idle;
    logic           w_run;
    logic           w_accept;
    logic           w_coef_we;
    logic [AW-1:0]  w_rd_addr;
    logic [AW-1:0]  w_coef_addr;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_run       = (r_state == ST_RUN) && !rst;
    assign w_accept    = w_idle && s_axis_tvalid;
    // Coefficients may only change between samples, so a result never
    // mixes old and new values; writes outside IDLE are dropped.
    assign w_coef_we   = w_idle && coef_wr;
    assign w_coef_addr = coef_addr & ADDR_MASK;
    // Tap k reads the sample accepted k samples before the current one.
    assign w_rd_addr   = (r_base - r_tap) & ADDR_MASK;

    // -----------------------------------------------------------------------
    // Delay line and coefficient RAM
    // CLEAR zeroes one location of each per cycle, so neither array needs a
    // reset of its own and both map onto plain RAM.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_dline[r_clr_cnt] <= '0;
            r_coef[r_clr_cnt]  <= '0;
        end else begin
            if (w_accept) begin
                r_dline[r_wptr] <= s_axis_tdata;
            end
            if (w_coef_we) begin
                r_coef[w_coef_addr] <= coef_data;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Sequencing FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_wptr    <= '0;
            r_base    <= '0;
            r_tap     <= '0;
            r_drain   <= '0;
            r_sload   <= 1'b0;
            r_tdata   <= '0;
        end else begin
            // sload lands on the cycle after tap 0 so macc_core reloads
            // its accumulator with the tap-0 product.
            r_sload <= (r_state == ST_RUN) && (r_tap == '0);

            case (r_state)
                ST_CLEAR: begin
                    r_wptr    <= '0;
                    r_clr_cnt <= (r_clr_cnt + 1'b1) & ADDR_MASK;
                    if (r_clr_cnt == LAST_TAP) begin
                        r_clr_cnt <= '0;
                        r_state   <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    if (s_axis_tvalid) begin
                        r_base  <= r_wptr;
                        r_wptr  <= (r_wptr + 1'b1) & ADDR_MASK;
                        r_tap   <= '0;
                        r_state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    r_tap <= (r_tap + 1'b1) & ADDR_MASK;
                    if (r_tap == LAST_TAP) begin
                        r_tap   <= '0;
                        r_drain <= '0;
                        r_state <= ST_DRAIN;
                    end
                end

                ST_DRAIN: begin
                    r_drain <= r_drain + 2'd1;
                    if (r_drain == DRAIN_LAST) begin
                        r_tdata <= macc_accum;
                        r_drain <= '0;
                        r_state <= ST_OUT;
                    end
                end

                ST_OUT: begin
                    if (m_axis_tready) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_CLEAR;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Operand drive: zero outside RUN so macc_core sees clean inputs
    // -----------------------------------------------------------------------
    always_comb begin
        macc_a = '0;
        macc_b = '0;
        if (w_run) begin
            macc_a = r_dline[w_rd_addr];
            macc_b = r_coef[r_tap];
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign macc_ce       = !rst;
    assign macc_sload    = r_sload;
    assign s_axis_tready = w_idle;
    assign coef_ready    = w_idle;
    assign m_axis_tvalid = (r_state == ST_OUT);
    assign m_axis_tdata  = r_tdata;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fir_tap_sequencer
//
// Self-checking bench for fir_tap_sequencer (NTAPS=4) together with a
// behavioural macc_core: operands registered, multiplied, then accumulated,
// with sload registered alongside the operands so it lines up with the tap-0
// product. Expected filter outputs are hand-computed constants or come from
// a direct-form FIR reference (newest sample first).
// ---------------------------------------------------------------------------
module tb_fir_tap_sequencer;

    localparam int SDW   = 24;
    localparam int CDW   = 18;
    localparam int ODW   = 48;
    localparam int NTAPS = 4;
    localparam int AW    = 2;
    localparam int LAT   = NTAPS + 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [SDW-1:0] s_axis_tdata = '0;
    logic           s_axis_tvalid = 1'b0;
    logic           s_axis_tready;
    logic [ODW-1:0] m_axis_tdata;
    logic           m_axis_tvalid;
    logic           m_axis_tready = 1'b1;
    logic           coef_wr = 1'b0;
    logic [AW-1:0]  coef_addr = '0;
    logic [CDW-1:0] coef_data = '0;
    logic           coef_ready;
    logic           macc_ce;
    logic           macc_sload;
    logic [SDW-1:0] macc_a;
    logic [CDW-1:0] macc_b;
    logic [ODW-1:0] macc_accum;

    fir_tap_sequencer #(
        .SDW   (SDW),
        .CDW   (CDW),
        .ODW   (ODW),
        .NTAPS (NTAPS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .coef_wr       (coef_wr),
        .coef_addr     (coef_addr),
        .coef_data     (coef_data),
        .coef_ready    (coef_ready),
        .macc_ce       (macc_ce),
        .macc_sload    (macc_sload),
        .macc_a        (macc_a),
        .macc_b        (macc_b),
        .macc_accum    (macc_accum)
    );

    always #5 clk = ~clk;

    // Behavioural macc_core
    logic signed [SDW-1:0] mc_a = '0;
    logic signed [CDW-1:0] mc_b = '0;
    logic signed [ODW-1:0] mc_m = '0;
    logic signed [ODW-1:0] mc_acc = '0;
    logic                  mc_sl = 1'b0;

    always @(posedge clk) begin
        if (macc_ce) begin
            mc_a   <= macc_a;
            mc_b   <= macc_b;
            mc_sl  <= macc_sload;
            mc_m   <= ODW'(longint'(mc_a) * longint'(mc_b));
            mc_acc <= mc_sl ? mc_m : mc_acc + mc_m;
        end
    end
    assign macc_accum = mc_acc;

    // Reference FIR state
    longint cref [NTAPS];
    longint hist [NTAPS];

    int n_pass  = 0;
    int n_total = 0;

    // Results of the most recent send_sample
    logic signed [ODW-1:0] r_y;
    logic signed [SDW-1:0] r_a0;
    int                    r_lat;
    int                    r_sl_off;
    int                    r_sl_cnt;
    bit                    r_tmo;
    logic                  r_cr_run;

    function automatic longint model_y();
        longint s = 0;
        for (int k = 0; k < NTAPS; k++) s += cref[k] * hist[k];
        return s;
    endfunction

    task automatic model_push(input longint x);
        for (int k = NTAPS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = x;
    endtask

    task automatic model_clear();
        for (int k = 0; k < NTAPS; k++) begin
            hist[k] = 0;
            cref[k] = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_coef(input int k, input longint v);
        coef_addr = AW'(k);
        coef_data = CDW'(v);
        coef_wr   = 1'b1;
        step();
        coef_wr   = 1'b0;
        cref[k]   = v;
    endtask

    // Sends one sample and returns in the first cycle m_axis_tvalid is seen.
    // Offsets count cycles after the accept cycle S (offset 1 = S+1).
    // With gate_wr set, a coefficient write to tap 0 is attempted during RUN.
    task automatic send_sample(input longint x, input bit gate_wr);
        int w;
        r_tmo = 1'b1; r_lat = -1; r_sl_off = -1; r_sl_cnt = 0;
        r_y = '0; r_a0 = '0; r_cr_run = 1'b1;
        w = 0;
        while (!s_axis_tready && w < 60) begin
            step();
            w++;
        end
        if (!s_axis_tready) return;
        s_axis_tdata  = SDW'(x);
        s_axis_tvalid = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        model_push(x);
        for (int off = 1; off <= 40; off++) begin
            if (off == 1) begin
                r_a0 = macc_a;
                if (gate_wr) begin
                    r_cr_run  = coef_ready;
                    coef_addr = '0;
                    coef_data = CDW'(100);
                    coef_wr   = 1'b1;
                end
            end
            if (off == 2) coef_wr = 1'b0;
            if (macc_sload) begin
                if (r_sl_off < 0) r_sl_off = off;
                r_sl_cnt++;
            end
            if (m_axis_tvalid) begin
                r_lat = off;
                r_y   = m_axis_tdata;
                r_tmo = 1'b0;
                return;
            end
            step();
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_total++; if (s_axis_tready !== 1'b0) $display("FAIL rst_s_ready got %b exp 0", s_axis_tready); else n_pass++;
        n_total++; if (coef_ready !== 1'b0) $display("FAIL rst_coef_ready got %b exp 0", coef_ready); else n_pass++;
        n_total++; if (m_axis_tvalid !== 1'b0) $display("FAIL rst_m_valid got %b exp 0", m_axis_tvalid); else n_pass++;
        n_total++; if (m_axis_tdata !== '0) $display("FAIL rst_m_data got %h exp 0", m_axis_tdata); else n_pass++;
        n_total++; if (macc_sload !== 1'b0) $display("FAIL rst_sload got %b exp 0", macc_sload); else n_pass++;
        n_total++; if (macc_a !== '0 || macc_b !== '0) $display("FAIL rst_operands got a=%h b=%h exp 0", macc_a, macc_b); else n_pass++;
        n_total++; if (macc_ce !== 1'b0) $display("FAIL rst_ce got %b exp 0", macc_ce); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++; if (macc_ce !== 1'b1) $display("FAIL ce_after_rst got %b exp 1", macc_ce); else n_pass++;
        for (int i = 1; i <= NTAPS; i++) begin
            step();
            n_total++;
            if (s_axis_tready !== (i == NTAPS))
                $display("FAIL clear_len cycle %0d s_ready got %b exp %b", i, s_axis_tready, (i == NTAPS));
            else n_pass++;
        end
        n_total++; if (coef_ready !== 1'b1) $display("FAIL idle_coef_ready got %b exp 1", coef_ready); else n_pass++;
        model_clear();
    endtask

    task automatic test_impulse();
        longint xs  [5] = '{1, 0, 0, 0, 0};
        longint exp [5] = '{1, 2, 3, 4, 0};
        for (int k = 0; k < NTAPS; k++) load_coef(k, k + 1);
        for (int i = 0; i < 5; i++) begin
            send_sample(xs[i], 1'b0);
            n_total++;
            if (r_tmo) begin
                $display("FAIL impulse[%0d] timeout got no tvalid exp tvalid", i);
                continue;
            end
            if (longint'(r_y) !== exp[i]) $display("FAIL impulse[%0d] y got %0d exp %0d", i, r_y, exp[i]);
            else n_pass++;
            n_total++; if (r_lat !== LAT) $display("FAIL impulse[%0d] latency got %0d exp %0d", i, r_lat, LAT); else n_pass++;
            if (i == 0) begin
                n_total++; if (r_sl_off !== 2) $display("FAIL sload_cycle got S+%0d exp S+2", r_sl_off); else n_pass++;
                n_total++; if (r_sl_cnt !== 1) $display("FAIL sload_count got %0d exp 1", r_sl_cnt); else n_pass++;
                n_total++; if (r_a0 !== SDW'(1)) $display("FAIL tap0_operand got %0d exp 1", r_a0); else n_pass++;
            end
            step();
        end
    endtask

    task automatic test_step();
        longint exp [6] = '{1, 3, 6, 10, 10, 10};
        for (int i = 0; i < 6; i++) begin
            send_sample(1, 1'b0);
            n_total++;
            if (r_tmo) begin
                $display("FAIL step[%0d] timeout got no tvalid exp tvalid", i);
                continue;
            end
            if (longint'(r_y) !== exp[i]) $display("FAIL step[%0d] y got %0d exp %0d", i, r_y, exp[i]);
            else n_pass++;
            n_total++; if (r_lat !== LAT) $display("FAIL step[%0d] latency got %0d exp %0d", i, r_lat, LAT); else n_pass++;
            step();
        end
    endtask

    task automatic test_full_scale();
        longint fs = longint'(1) <<< 42;
        for (int k = 0; k < NTAPS; k++) load_coef(k, -131072);
        for (int i = 0; i < 5; i++) begin
            send_sample(-8388608, 1'b0);
            n_total++;
            if (r_tmo) begin
                $display("FAIL full_scale[%0d] timeout got no tvalid exp tvalid", i);
                continue;
            end
            if (i >= 3) begin
                if (longint'(r_y) !== fs) $display("FAIL full_scale[%0d] y got %0d exp %0d", i, r_y, fs);
                else n_pass++;
            end else begin
                if (longint'(r_y) !== model_y()) $display("FAIL full_scale[%0d] y got %0d exp %0d", i, r_y, model_y());
                else n_pass++;
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic signed [ODW-1:0] held;
        for (int k = 0; k < NTAPS; k++) load_coef(k, k + 1);
        for (int i = 0; i < 20; i++) begin
            longint x = longint'((i * 37) % 101 - 50) * 1000 + i;
            m_axis_tready = (i % 5 != 0);
            send_sample(x, 1'b0);
            n_total++;
            if (r_tmo) begin
                $display("FAIL bp[%0d] timeout got no tvalid exp tvalid", i);
                m_axis_tready = 1'b1;
                continue;
            end
            if (longint'(r_y) !== model_y()) $display("FAIL bp[%0d] y got %0d exp %0d", i, r_y, model_y());
            else n_pass++;
            if (!m_axis_tready) begin
                held = r_y;
                for (int c = 0; c < 10; c++) begin
                    step();
                    n_total++;
                    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held || s_axis_tready !== 1'b0)
                        $display("FAIL bp_hold[%0d] cycle %0d got v=%b d=%0d r=%b exp v=1 d=%0d r=0",
                                 i, c, m_axis_tvalid, $signed(m_axis_tdata), s_axis_tready, held);
                    else n_pass++;
                end
                m_axis_tready = 1'b1;
            end
            step();
        end
        m_axis_tready = 1'b1;
    endtask

    task automatic test_coef_gating();
        for (int k = 0; k < NTAPS; k++) load_coef(k, k + 1);
        send_sample(5, 1'b1);
        n_total++;
        if (r_tmo) $display("FAIL gate_run timeout got no tvalid exp tvalid");
        else if (longint'(r_y) !== model_y()) $display("FAIL gate_run y got %0d exp %0d", r_y, model_y());
        else n_pass++;
        n_total++; if (r_cr_run !== 1'b0) $display("FAIL gate_coef_ready got %b exp 0", r_cr_run); else n_pass++;
        step();
        load_coef(0, 100);
        send_sample(7, 1'b0);
        n_total++;
        if (r_tmo) $display("FAIL gate_idle timeout got no tvalid exp tvalid");
        else if (longint'(r_y) !== model_y()) $display("FAIL gate_idle y got %0d exp %0d", r_y, model_y());
        else n_pass++;
        step();
    endtask

    task automatic test_reset_mid_run();
        longint exp [4] = '{1, 2, 3, 4};
        int w = 0;
        for (int k = 0; k < NTAPS; k++) load_coef(k, k + 5);
        while (!s_axis_tready && w < 60) begin
            step();
            w++;
        end
        s_axis_tdata  = SDW'(9);
        s_axis_tvalid = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
        model_push(9);
        step();
        step();
        n_total++;
        if (macc_a !== SDW'(hist[2]) || macc_b !== CDW'(cref[2]))
            $display("FAIL tap2_operands got a=%0d b=%0d exp a=%0d b=%0d", $signed(macc_a), $signed(macc_b), hist[2], cref[2]);
        else n_pass++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < NTAPS; c++) begin
            n_total++;
            if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0)
                $display("FAIL mid_rst cycle %0d got ready=%b valid=%b exp 0 0", c, s_axis_tready, m_axis_tvalid);
            else n_pass++;
            step();
        end
        n_total++; if (s_axis_tready !== 1'b1) $display("FAIL mid_rst_idle got %b exp 1", s_axis_tready); else n_pass++;
        model_clear();
        for (int k = 0; k < NTAPS; k++) load_coef(k, k + 1);
        for (int i = 0; i < 4; i++) begin
            send_sample((i == 0) ? 1 : 0, 1'b0);
            n_total++;
            if (r_tmo) begin
                $display("FAIL post_rst[%0d] timeout got no tvalid exp tvalid", i);
                continue;
            end
            if (longint'(r_y) !== exp[i]) $display("FAIL post_rst[%0d] y got %0d exp %0d", i, r_y, exp[i]);
            else n_pass++;
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no completion exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        test_reset();
        test_impulse();
        test_step();
        test_full_scale();
        test_backpressure();
        test_coef_gating();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fir_tap_sequencer.md
# fir_tap_sequencer

Time-multiplexed FIR control stage that sits directly upstream of `macc_core`. It accepts one input sample per stream handshake and keeps it in a circular delay line. It then issues NTAPS coefficient/sample operand pairs to the multiply-accumulate core, with the correctly timed `sload`, and emits the full-precision accumulator result as an output stream sample. It supplies one `macc_core` with all of its control and operands, so a single DSP slice computes the whole filter.

## Interface
- SDW, 24: sample width; drives `macc_core` ADW.
- CDW, 18: coefficient width; drives `macc_core` BDW.
- ODW, 48: accumulator/output width; drives `macc_core` ODW.
- NTAPS, 16: filter length, ≥1. Must be a power of two so that pointer wrap is a natural overflow.
- AW, $clog2(NTAPS): tap address width, derived and not user-set.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- s_axis_tdata  in  SDW  signed input sample.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  ODW  signed filter output y[n].
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- coef_wr  in  1  coefficient write strobe.
- coef_addr  in  AW  tap index k.
- coef_data  in  CDW  signed coefficient c[k].
- coef_ready  out  1  coefficient write accepted when high.
- macc_ce  out  1  to `macc_core.ce`.
- macc_sload  out  1  to `macc_core.sload`.
- macc_a  out  SDW  to `macc_core.a` (sample).
- macc_b  out  CDW  to `macc_core.b` (coefficient).
- macc_accum  in  ODW  from `macc_core.accum_o`.

## Operation
- Function: y[n] = Σ_{k=0..NTAPS-1} c[k]·x[n-k], exact in ODW bits; no rounding and no saturation. The integrator guarantees NTAPS·2^(SDW+CDW-2) < 2^(ODW-1).
- Delay line: NTAPS×SDW array with write pointer wptr.
  - An accepted sample is written at wptr and wptr increments, wrapping mod NTAPS.
  - Tap k reads address (wptr_at_accept − k) mod NTAPS.
- Coefficient RAM: NTAPS×CDW.
  - A write occurs when coef_wr && coef_ready.
  - If coef_ready=0, coef_wr is ignored (dropped), not queued.
- FSM states:
  - CLEAR: entered on rst. Writes 0 to the delay-line and coefficient location at a counter, one per cycle, for NTAPS cycles, then goes to IDLE. wptr=0.
  - IDLE: s_axis_tready=1, coef_ready=1. On s_axis_tvalid, the sample is accepted and the FSM goes to RUN with tap counter=0.
  - RUN: each cycle drives macc_a=x[n-k], macc_b=c[k], and increments k. After k=NTAPS-1 it goes to DRAIN.
  - DRAIN: waits for pipeline latency, then captures macc_accum into m_axis_tdata and goes to OUT.
  - OUT: m_axis_tvalid=1, holding m_axis_tdata stable. On m_axis_tready, goes to IDLE.
- Operand rules:
  - macc_a and macc_b are 0 in every cycle outside RUN.
  - macc_ce=1 in every cycle except while rst is high.
- sload rule: `macc_core` applies sload one cycle after the operand pair it clears for. Therefore macc_sload=1 for exactly one cycle, the cycle after tap 0 is driven, and is 0 otherwise.
  - For NTAPS=1 this falls in the first DRAIN cycle.
- Reset mid-operation: rst in any state returns to CLEAR.
  - The in-flight result is discarded; m_axis_tvalid drops the cycle after rst.
  - The delay line and coefficients are re-zeroed.
- Coefficient update: only in IDLE, so a result never mixes old and new coefficients.

## Timing
- Reset values:
  - s_axis_tready=0, coef_ready=0, m_axis_tvalid=0, m_axis_tdata=0.
  - macc_sload=0, macc_a=0, macc_b=0.
  - macc_ce=0 while rst is high, 1 thereafter.
- First IDLE (s_axis_tready=1) occurs NTAPS cycles after rst deasserts.
- Sample accepted in cycle S (tvalid && tready):
  - Tap k is driven in cycle S+1+k.
  - macc_sload is high in cycle S+2.
- The `macc_core` result is valid on macc_accum in cycle S+NTAPS+3. It is registered into m_axis_tdata, with m_axis_tvalid=1 from cycle S+NTAPS+4.
- s_axis_tready is 0 from S+1 until the cycle after the output handshake.
- Maximum rate: one sample per NTAPS+5 cycles with m_axis_tready held high.
- Output stream: tdata and tvalid must not change while tvalid && !tready.

## Test plan
- NTAPS=4, c=[1,2,3,4], impulse x=1,0,0,0,0 -> outputs 1,2,3,4,0.
- NTAPS=4, c=[1,2,3,4], step x=1×6 -> outputs 1,3,6,10,10,10. Check m_axis_tvalid rises exactly in cycle S+8 after each accept.
- Full-scale: NTAPS=4, all c=−2^17, x=−2^23 repeated -> 4th and later outputs exactly 2^42, with no sign error.
- Backpressure: m_axis_tready low 10 cycles -> tdata stable, s_axis_tready=0 throughout, no sample lost over 20 samples (wraps wptr 5×). Output sequence matches the reference model.
- Coefficient gating: coef_wr asserted during RUN -> write dropped and output unchanged; same write in IDLE -> next output uses the new c[k].
- Reset during RUN at tap 2 -> m_axis_tvalid stays 0, s_axis_tready=0 for 4 cycles. The next impulse with reloaded coefficients yields an exact impulse response with no stale history.
